axis_result_tx: RTL and testbench
=================================

AXIS_RESULT_TX -- requirements
Module: axis_result_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 64: tdata width in bits.
REQ-002 Parameter PACKETS_NUM, default 13: beats per frame.
REQ-003 Parameter DEPTH, default 4: FIFO entries, power of two, at least 2.
REQ-004 Parameter CNT_WIDTH, default 16: width of frames_sent.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 res_data  in  DATA_WIDTH  result word from core.
REQ-008 res_last  in  1  forces early frame end on this word.
REQ-009 res_valid  in  1  core offers word.
REQ-010 res_ready  out  1  block accepts word.
REQ-011 m_axis_tdata  out  DATA_WIDTH  stream data.
REQ-012 m_axis_tkeep  out  DATA_WIDTH/8  byte enables.
REQ-013 m_axis_tvalid  out  1  beat valid.
REQ-014 m_axis_tready  in  1  sink ready.
REQ-015 m_axis_tlast  out  1  final beat of frame.
REQ-016 m_axis_tuser  out  1  start-of-frame flag.
REQ-017 full  out  1  FIFO full.
REQ-018 count  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-019 frame_done  out  1  one-cycle pulse per completed frame.
REQ-020 frames_sent  out  CNT_WIDTH  completed-frame counter.

Function
REQ-021 The core-side push SHALL occur on a clk edge with res_valid && res_ready, storing {res_last, res_data}.
REQ-022 res_ready SHALL equal !full, with full registered (count==DEPTH); there SHALL be no push-while-full bypass, even with a simultaneous pop.
REQ-023 The stream-side pop SHALL occur on a clk edge with m_axis_tvalid && m_axis_tready.
REQ-024 m_axis_tvalid SHALL equal (count!=0); tdata SHALL be the FIFO head; a word pushed into an empty FIFO at edge k SHALL be presented after edge k (1-cycle latency).
REQ-025 Once m_axis_tvalid is high, it and all m_axis payload SHALL hold stable until the pop.
REQ-026 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-027 m_axis_tkeep SHALL be all ones.
REQ-028 FSM states: IDLE (no frame open) and ACTIVE (frame open); beat_cnt ranges 0..PACKETS_NUM-1.
REQ-029 IDLE->ACTIVE on a pop without tlast; ACTIVE->IDLE on a pop with tlast; a pop with tlast in IDLE (1-beat frame) SHALL stay in IDLE.
REQ-030 m_axis_tuser SHALL be 1 exactly when the state is IDLE and m_axis_tvalid is high.
REQ-031 m_axis_tlast SHALL equal head.res_last || (beat_cnt==PACKETS_NUM-1).
REQ-032 beat_cnt SHALL increment on each pop and clear to 0 on a pop with tlast.
REQ-033 frame_done SHALL pulse high for exactly the cycle after a pop with tlast.
REQ-034 frames_sent SHALL increment on the same edge that raises frame_done, wrapping modulo 2^CNT_WIDTH.
REQ-035 With PACKETS_NUM==1, every beat SHALL carry tuser=1 and tlast=1.

Reset
REQ-036 While rst_n is low, asynchronously: count=0, full=0, res_ready=0, m_axis_tvalid=0, m_axis_tuser=0, frame_done=0, frames_sent=0, beat_cnt=0, pointers=0, state=IDLE.
REQ-037 FIFO storage SHALL NOT be reset; m_axis_tdata and m_axis_tlast SHALL be don't-care while tvalid is 0.
REQ-038 Reset asserted mid-frame SHALL discard FIFO contents and the open frame; the first beat after release SHALL carry tuser=1.
REQ-039 res_ready SHALL go high on the first clk edge after rst_n deasserts.

Structure
REQ-040 Package axis_tx_pkg SHALL hold the state enum (IDLE, ACTIVE) and default parameter constants.
REQ-041 The FIFO SHALL be a sub-module named axis_tx_fifo (storage, pointers, count, full); the FSM, counters and sideband logic SHALL live in the top level.

Verification
REQ-042 PACKETS_NUM=3, tready=1, push 0x1,0x2,0x3: tuser on 0x1 only, tlast on 0x3, frame_done pulse, frames_sent=1.
REQ-043 Push 0xA then 0xB with res_last=1: 2-beat frame with tlast on 0xB, beat_cnt=0 after, next beat tuser=1.
REQ-044 tready=0, push DEPTH=4 words: full=1, res_ready=0, count=4; raise tready: four beats in order, count reaches 0.
REQ-045 Random tready stalls: tdata, tlast and tuser stable while tvalid && !tready; no lost or duplicated words across 1000 words.
REQ-046 rst_n low after 2 beats of a 13-beat frame: outputs clear immediately; next frame starts with tuser=1, frames_sent=0.
REQ-047 Force frames_sent to 0xFFFF, complete one frame: frames_sent=0x0000, frame_done pulses once.

Source files
------------

// File: rtl/axis_tx_pkg.sv
// Shared definitions for the result-stream transmitter.
// Holds the frame FSM state type, default parameter values and a helper
// that sizes the in-frame beat counter.
package axis_tx_pkg;

    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_PACKETS_NUM = 13;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_CNT_WIDTH   = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } tx_state_t;

    // A one-beat frame still needs a 1-bit counter so the compare is legal.
    function automatic int beat_cnt_width(input int packets);
        return (packets > 1) ? $clog2(packets) : 1;
    endfunction

endpackage

// File: rtl/axis_tx_fifo.sv
// Synchronous FIFO between the result core and the AXI-Stream output.
// Ports:
//   clk, rst_n  - clock, async active-low reset (pointers/count/full only)
//   i_push      - write request; ignored while full, even on a same-cycle pop
//   i_wdata     - word to store
//   i_pop       - read request; ignored while empty
//   o_rdata     - current head word
//   o_full      - registered (count == DEPTH)
//   o_count     - occupancy
module axis_tx_fifo
    import axis_tx_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic [CW-1:0]    w_count_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is intentionally not reset; its contents are only observed
    // while the count says the entry is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule

// File: rtl/axis_result_tx.sv
// Packs core result words into fixed-length AXI-Stream frames.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   res_data/last/valid/ready  - core-side push interface
//   m_axis_*                   - stream master (tkeep all ones, tuser = SOF)
//   full, count                - FIFO status
//   frame_done                 - one-cycle pulse after the tlast beat pops
//   frames_sent                - wrapping completed-frame counter
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | no frame open; next popped beat starts a frame
// ST_ACTIVE | frame open; beats continue until tlast pops
module axis_result_tx
    import axis_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PACKETS_NUM = DEF_PACKETS_NUM,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      res_data,
    input  logic                       res_last,
    input  logic                       res_valid,
    output logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       frame_done,
    output logic [CNT_WIDTH-1:0]       frames_sent
);

    localparam int BCW = beat_cnt_width(PACKETS_NUM);
    localparam int CW  = $clog2(DEPTH + 1);

    tx_state_t             r_state;
    tx_state_t             w_state_nxt;
    logic [BCW-1:0]        r_beat_cnt;
    logic [BCW-1:0]        w_beat_nxt;
    logic                  r_rst_done;
    logic                  r_frame_done;
    logic [CNT_WIDTH-1:0]  r_frames_sent;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_full;
    logic [CW-1:0]         w_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tvalid;
    logic                  w_tlast;

    // Holds res_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_done <= 1'b0;
        else        r_rst_done <= 1'b1;
    end

    assign res_ready = r_rst_done && !w_full;
    assign w_push    = res_valid && res_ready;
    assign w_tvalid  = (w_count != '0);
    assign w_pop     = w_tvalid && m_axis_tready;

    axis_tx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({res_last, res_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign w_tlast = w_head[DATA_WIDTH] || (r_beat_cnt == BCW'(PACKETS_NUM - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        if (w_pop) begin
            if (w_tlast) begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end else begin
                w_state_nxt = ST_ACTIVE;
                w_beat_nxt  = r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done  <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_frame_done <= w_pop && w_tlast;
            if (w_pop && w_tlast) r_frames_sent <= r_frames_sent + 1'b1;
        end
    end

    assign m_axis_tdata  = w_head[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = '1;
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tlast  = w_tlast;
    assign m_axis_tuser  = (r_state == ST_IDLE) && w_tvalid;
    assign full          = w_full;
    assign count         = w_count;
    assign frame_done    = r_frame_done;
    assign frames_sent   = r_frames_sent;

endmodule

// File: tb/tb_axis_result_tx.sv
module tb_axis_result_tx;

    localparam int P  = 3;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        u;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   res_data;
    logic          res_last, res_valid, res_ready;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;
    logic          tvalid, tready, tlast, tuser, full;
    logic [CW-1:0] count;
    logic          frame_done;
    logic [15:0]   frames_sent;

    logic [15:0]   res_data2;
    logic          res_last2, res_valid2, res_ready2;
    logic [15:0]   tdata2;
    logic [1:0]    tkeep2;
    logic          tvalid2, tready2, tlast2, tuser2, full2;
    logic [CW-1:0] count2;
    logic          frame_done2;
    logic [3:0]    frames_sent2;

    int   total = 0;
    int   bad = 0;
    int   n_tmo;
    bit   drv_done, final_req, final_ack, seen_edge;
    exp_t q[$];
    logic [15:0] q2[$];

    always #5 clk = ~clk;

    axis_result_tx #(.DATA_WIDTH(64), .PACKETS_NUM(P), .DEPTH(D), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .res_data(res_data), .res_last(res_last),
        .res_valid(res_valid), .res_ready(res_ready), .m_axis_tdata(tdata),
        .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser), .full(full), .count(count),
        .frame_done(frame_done), .frames_sent(frames_sent));

    axis_result_tx #(.DATA_WIDTH(16), .PACKETS_NUM(1), .DEPTH(D), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .res_data(res_data2), .res_last(res_last2),
        .res_valid(res_valid2), .res_ready(res_ready2), .m_axis_tdata(tdata2),
        .m_axis_tkeep(tkeep2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
        .m_axis_tlast(tlast2), .m_axis_tuser(tuser2), .full(full2), .count(count2),
        .frame_done(frame_done2), .frames_sent(frames_sent2));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_edge <= 1'b0;
        else        seen_edge <= 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor + reference model: frame position is tracked per pushed word,
    // so the expected tuser/tlast of each beat is known at push time.
    initial begin : monitor
        exp_t        e;
        int          idx;
        int          exp_frames, exp_frames2;
        bit          pend, pend2, hold;
        logic [63:0] hd;
        logic        hl, hu;
        idx = 0; exp_frames = 0; exp_frames2 = 0;
        pend = 0; pend2 = 0; hold = 0; hd = '0; hl = 0; hu = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                q.delete(); q2.delete();
                idx = 0; exp_frames = 0; exp_frames2 = 0;
                pend = 0; pend2 = 0; hold = 0;
                chk("rst_tvalid", 64'(tvalid), 64'(0));
                chk("rst_tuser", 64'(tuser), 64'(0));
                chk("rst_count", 64'(count), 64'(0));
                chk("rst_full", 64'(full), 64'(0));
                chk("rst_ready", 64'(res_ready), 64'(0));
                chk("rst_done", 64'(frame_done), 64'(0));
                chk("rst_frames", 64'(frames_sent), 64'(0));
                chk("rst_tvalid2", 64'(tvalid2), 64'(0));
                chk("rst_frames2", 64'(frames_sent2), 64'(0));
            end else begin
                chk("count", 64'(count), 64'(q.size()));
                chk("full", 64'(full), 64'(q.size() == D));
                chk("res_ready", 64'(res_ready), 64'(seen_edge && q.size() < D));
                chk("tvalid", 64'(tvalid), 64'(q.size() != 0));
                chk("tkeep", 64'(tkeep), 64'(8'hFF));
                chk("frame_done", 64'(frame_done), 64'(pend));
                chk("frames_sent", 64'(frames_sent), 64'(exp_frames));
                pend = 0;
                if (hold) begin
                    chk("stall_tvalid", 64'(tvalid), 64'(1));
                    chk("stall_tdata", tdata, hd);
                    chk("stall_tlast", 64'(tlast), 64'(hl));
                    chk("stall_tuser", 64'(tuser), 64'(hu));
                end
                hold = 0;
                if (tvalid && q.size() != 0) begin
                    e = q[0];
                    chk("tdata", tdata, e.d);
                    chk("tlast", 64'(tlast), 64'(e.l));
                    chk("tuser", 64'(tuser), 64'(e.u));
                    if (tready) begin
                        void'(q.pop_front());
                        if (e.l) begin
                            pend = 1;
                            exp_frames = (exp_frames + 1) % 65536;
                        end
                    end else begin
                        hold = 1; hd = tdata; hl = tlast; hu = tuser;
                    end
                end
                if (res_valid && res_ready) begin
                    e.d = res_data;
                    e.u = (idx == 0);
                    e.l = res_last || (idx == P - 1);
                    idx = e.l ? 0 : idx + 1;
                    q.push_back(e);
                end

                chk("count2", 64'(count2), 64'(q2.size()));
                chk("full2", 64'(full2), 64'(q2.size() == D));
                chk("tkeep2", 64'(tkeep2), 64'(2'b11));
                chk("frame_done2", 64'(frame_done2), 64'(pend2));
                chk("frames_sent2", 64'(frames_sent2), 64'(exp_frames2));
                pend2 = 0;
                if (tvalid2 && tready2 && q2.size() != 0) begin
                    chk("tdata2", 64'(tdata2), 64'(q2[0]));
                    chk("tuser2", 64'(tuser2), 64'(1));
                    chk("tlast2", 64'(tlast2), 64'(1));
                    void'(q2.pop_front());
                    pend2 = 1;
                    exp_frames2 = (exp_frames2 + 1) % 16;
                end
                if (res_valid2 && res_ready2) q2.push_back(res_data2);

                if (final_req && !final_ack) begin
                    chk("timeouts", 64'(n_tmo), 64'(0));
                    chk("drained", 64'(q.size() + q2.size()), 64'(0));
                    final_ack = 1;
                end
            end
        end
    end

    task automatic push1(input logic [63:0] d, input logic l);
        int n = 0;
        bit ok = 0;
        res_data = d; res_last = l; res_valid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk); ok = res_ready;
            @(posedge clk); #1; n++;
        end
        res_valid = 1'b0;
        if (!ok) n_tmo++;
    endtask

    task automatic push2(input logic [15:0] d);
        int n = 0;
        bit ok = 0;
        res_data2 = d; res_last2 = 1'b0; res_valid2 = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk); ok = res_ready2;
            @(posedge clk); #1; n++;
        end
        res_valid2 = 1'b0;
        if (!ok) n_tmo++;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (q.size() != 0 || q2.size() != 0) n_tmo++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        rst_n = 1'b0; res_data = '0; res_last = 0; res_valid = 0; tready = 0;
        res_data2 = '0; res_last2 = 0; res_valid2 = 0; tready2 = 0;
        n_tmo = 0; drv_done = 0; final_req = 0; final_ack = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 3-beat frame by length
        tready = 1;
        push1(64'h1, 0); push1(64'h2, 0); push1(64'h3, 0);
        drain();

        // early end via res_last, then a fresh frame
        push1(64'hA, 0); push1(64'hB, 1);
        push1(64'hC, 0); push1(64'hD, 0); push1(64'hE, 0);
        drain();

        // fill to full with the sink stalled, then release
        tready = 0;
        for (int i = 0; i < D; i++) push1(64'h100 + 64'(i), 0);
        repeat (3) @(posedge clk);
        #1 tready = 1;
        drain();

        // random stalls and gaps
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                    push1({$urandom, $urandom}, $urandom_range(7) == 0);
                end
                drv_done = 1;
            end
            begin
                int n = 0;
                while ((!drv_done || q.size() != 0) && n < 20000) begin
                    @(posedge clk); #1;
                    tready = ($urandom_range(1) == 1);
                    n++;
                end
                tready = 1;
            end
        join
        drain();

        // close any frame left open, then reset two beats into a new frame
        push1(64'h55, 1);
        drain();
        push1(64'h201, 0); push1(64'h202, 0);
        drain();
        tready = 0;
        push1(64'h203, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        tready = 1;
        push1(64'h301, 0); push1(64'h302, 0); push1(64'h303, 0);
        drain();

        // one-beat frames and 4-bit counter wrap
        tready2 = 1;
        for (int i = 0; i < 20; i++) push2(16'($urandom_range(65535)));
        drain();

        final_req = 1;
        for (int n = 0; n < 20 && !final_ack; n++) @(posedge clk);
        if (!final_ack) begin
            bad++;
            $display("FAIL final_check: got no ack want ack");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
